// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage CPU pipeline control.
package cpu_pkg;

   typedef enum logic [2:0] {
      RUN,
      LU_STALL,
      FU_STALL,
      DRAIN,
      HALTED
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int REG_ZERO = 0;

   function automatic logic [1:0] fwd_pick(input logic hit_mem,
                                           input logic hit_wb);
      if (hit_mem)
         return FWD_MEM;
      else if (hit_wb)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding comparator for one EX source operand; EX/MEM beats MEM/WB,
// and register 0 never matches.
module fwd_unit
   import cpu_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] i_src,
   input  logic [REG_W-1:0] i_mem_rd,
   input  logic             i_mem_we,
   input  logic [REG_W-1:0] i_wb_rd,
   input  logic             i_wb_we,
   output logic [1:0]       o_sel
);

   logic w_hit_mem;
   logic w_hit_wb;

   assign w_hit_mem = i_mem_we && (i_mem_rd == i_src)
                   && (i_mem_rd != REG_W'(REG_ZERO));
   assign w_hit_wb  = i_wb_we && (i_wb_rd == i_src)
                   && (i_wb_rd != REG_W'(REG_ZERO));

   assign o_sel = fwd_pick(w_hit_mem, w_hit_wb);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard, flush, forwarding and HLT-drain sequencing controller.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_W        = 4,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_cond_branch,
   input  logic             id_halt,
   input  logic             branch_taken,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             ex_setflags,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_regwrite,
   input  logic [REG_W-1:0] exs_rs,
   input  logic [REG_W-1:0] exs_rt,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2,
   output logic             halted
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]      lu_stall_cnt,
   output logic [15:0]      fu_stall_cnt,
   output logic [15:0]      flush_cnt
`endif
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   state_t           w_next;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_lu;
   logic             w_fu;
   logic             w_pc;
   logic             w_stall;
   logic             w_flush;
   logic             w_bubble;
   logic             w_halted;

   fwd_unit #(.REG_W(REG_W)) u_fwd1 (
      .i_src    (exs_rs),
      .i_mem_rd (mem_rd),
      .i_mem_we (mem_regwrite),
      .i_wb_rd  (wb_rd),
      .i_wb_we  (wb_regwrite),
      .o_sel    (fwd_sel1)
   );

   fwd_unit #(.REG_W(REG_W)) u_fwd2 (
      .i_src    (exs_rt),
      .i_mem_rd (mem_rd),
      .i_mem_we (mem_regwrite),
      .i_wb_rd  (wb_rd),
      .i_wb_we  (wb_regwrite),
      .o_sel    (fwd_sel2)
   );

   assign w_lu = ex_memread && (ex_rd != REG_W'(REG_ZERO))
              && ((id_use_rs && (ex_rd == id_rs))
               || (id_use_rt && (ex_rd == id_rt)));
   assign w_fu = id_cond_branch && ex_setflags;

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_pc      = 1'b0;
      w_stall   = 1'b0;
      w_flush   = 1'b0;
      w_bubble  = 1'b0;
      w_halted  = 1'b0;
      case (r_state)
         RUN, LU_STALL, FU_STALL: begin
            w_next = RUN;
            if (w_lu || w_fu) begin
               w_pc     = 1'b1;
               w_stall  = 1'b1;
               w_bubble = 1'b1;
               w_next   = w_lu ? LU_STALL : FU_STALL;
            end else if (id_halt) begin
               // HLT is not a branch, so it outranks a taken branch
               w_pc      = 1'b1;
               w_flush   = 1'b1;
               w_next    = DRAIN;
               w_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
            end else if (branch_taken) begin
               w_flush = 1'b1;
            end
         end
         DRAIN: begin
            w_pc    = 1'b1;
            w_flush = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
               w_next    = HALTED;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         HALTED: begin
            w_pc     = 1'b1;
            w_stall  = 1'b1;
            w_halted = 1'b1;
         end
         default: begin
            w_next    = RUN;
            w_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Gate with reset so controls drop the moment rst falls
   assign pc_stall    = rst && w_pc;
   assign ifid_stall  = rst && w_stall;
   assign ifid_flush  = rst && w_flush;
   assign idex_bubble = rst && w_bubble;
   assign halted      = rst && w_halted;

`ifdef HAZARD_PERF_EN
   logic [15:0] r_lu_cnt;
   logic [15:0] r_fu_cnt;
   logic [15:0] r_fl_cnt;
   logic        w_lu_act;
   logic        w_fu_act;

   assign w_lu_act = w_bubble && w_lu;
   assign w_fu_act = w_bubble && !w_lu;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lu_cnt <= '0;
         r_fu_cnt <= '0;
         r_fl_cnt <= '0;
      end else if (r_state != HALTED) begin
         if (w_lu_act && (r_lu_cnt != 16'hFFFF))
            r_lu_cnt <= r_lu_cnt + 16'd1;
         if (w_fu_act && (r_fu_cnt != 16'hFFFF))
            r_fu_cnt <= r_fu_cnt + 16'd1;
         if (w_flush && (r_fl_cnt != 16'hFFFF))
            r_fl_cnt <= r_fl_cnt + 16'd1;
      end
   end

   assign lu_stall_cnt = r_lu_cnt;
   assign fu_stall_cnt = r_fu_cnt;
   assign flush_cnt    = r_fl_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level reference model
// built from the hazard, branch, halt and drain rules.
module tb_hazard_ctrl;

   localparam int REG_W = 4;
   localparam int DRAIN = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [REG_W-1:0] id_rs = '0, id_rt = '0;
   logic             id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic             id_cond_branch = 1'b0, id_halt = 1'b0;
   logic             branch_taken = 1'b0;
   logic [REG_W-1:0] ex_rd = '0;
   logic             ex_regwrite = 1'b0, ex_memread = 1'b0;
   logic             ex_setflags = 1'b0;
   logic [REG_W-1:0] mem_rd = '0, wb_rd = '0;
   logic             mem_regwrite = 1'b0, wb_regwrite = 1'b0;
   logic [REG_W-1:0] exs_rs = '0, exs_rt = '0;
   logic             pc_stall, ifid_stall, ifid_flush, idex_bubble;
   logic [1:0]       fwd_sel1, fwd_sel2;
   logic             halted;

   int n_cmp = 0;
   int n_bad = 0;

   // model: remaining drain cycles and sticky halt
   int m_drain  = 0;
   bit m_halted = 1'b0;
   int halt_age = 0;

   hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_cond_branch(id_cond_branch), .id_halt(id_halt),
      .branch_taken(branch_taken),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_setflags(ex_setflags),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .exs_rs(exs_rs), .exs_rt(exs_rt),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] src);
      if (mem_regwrite && mem_rd != 0 && mem_rd == src)
         return 2'b01;
      if (wb_regwrite && wb_rd != 0 && wb_rd == src)
         return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk_fwd();
      chk("fwd_sel1", 16'(fwd_sel1), 16'(ref_fwd(exs_rs)));
      chk("fwd_sel2", 16'(fwd_sel2), 16'(ref_fwd(exs_rt)));
   endtask

   task automatic chk_all(input bit pc, input bit st, input bit fl,
                          input bit bu, input bit hl);
      chk("pc_stall",    16'(pc_stall),    16'(pc));
      chk("ifid_stall",  16'(ifid_stall),  16'(st));
      chk("ifid_flush",  16'(ifid_flush),  16'(fl));
      chk("idex_bubble", 16'(idex_bubble), 16'(bu));
      chk("halted",      16'(halted),      16'(hl));
      chk_fwd();
   endtask

   task automatic randomize_inputs();
      id_rs          = REG_W'($urandom_range(0, 3));
      id_rt          = REG_W'($urandom_range(0, 3));
      id_use_rs      = 1'($urandom_range(0, 1));
      id_use_rt      = 1'($urandom_range(0, 1));
      id_cond_branch = ($urandom_range(0, 2) == 0);
      id_halt        = ($urandom_range(0, 24) == 0);
      branch_taken   = ($urandom_range(0, 2) == 0);
      ex_rd          = REG_W'($urandom_range(0, 3));
      ex_regwrite    = 1'($urandom_range(0, 1));
      ex_memread     = ($urandom_range(0, 2) == 0);
      ex_setflags    = ($urandom_range(0, 3) == 0);
      mem_rd         = REG_W'($urandom_range(0, 3));
      mem_regwrite   = 1'($urandom_range(0, 1));
      wb_rd          = REG_W'($urandom_range(0, 3));
      wb_regwrite    = 1'($urandom_range(0, 1));
      exs_rs         = REG_W'($urandom_range(0, 3));
      exs_rt         = REG_W'($urandom_range(0, 3));
   endtask

   // Expected controls for this cycle, then advance the model one cycle.
   task automatic model_cycle();
      bit lu, fu;
      if (m_halted) begin
         chk_all(1, 1, 0, 0, 1);
         halt_age++;
      end else if (m_drain > 0) begin
         chk_all(1, 0, 1, 0, 0);
         m_drain--;
         if (m_drain == 0) m_halted = 1'b1;
      end else begin
         lu = ex_memread && ex_rd != 0
           && ((id_use_rs && ex_rd == id_rs)
            || (id_use_rt && ex_rd == id_rt));
         fu = id_cond_branch && ex_setflags;
         if (lu || fu) begin
            chk_all(1, 1, 0, 1, 0);
         end else if (id_halt) begin
            chk_all(1, 0, 1, 0, 0);
            m_drain = DRAIN - 1;
            if (m_drain == 0) m_halted = 1'b1;
         end else begin
            chk_all(0, 0, branch_taken, 0, 0);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk_all(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_all(0, 0, 0, 0, 0);
      rst = 1'b1;
      m_drain  = 0;
      m_halted = 1'b0;
      halt_age = 0;
   endtask

   initial begin
      randomize_inputs();
      #1;
      chk_all(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         randomize_inputs();
         #1;
         model_cycle();
         if (m_drain > 0 && $urandom_range(0, 3) == 0)
            do_reset();
         else if (halt_age > 6)
            do_reset();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
